// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state encoding and helpers for mem_arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_IF_BUSY  = 2'b01,
        ARB_MEM_BUSY = 2'b10
    } arb_state_e;

    localparam logic        RST_ENABLE      = 1'b1;
    localparam logic        CHIP_ENABLE     = 1'b1;
    localparam logic        CHIP_DISABLE    = 1'b0;
    localparam logic        WRITE_ENABLE    = 1'b1;
    localparam logic        WRITE_DISABLE   = 1'b0;
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
    localparam logic [3:0]  SEL_ALL         = 4'b1111;
    localparam int          DEFAULT_TIMEOUT = 255;

    // A port may be granted only while it requests and is not in its done cycle.
    function automatic logic port_eligible(input logic req, input logic done);
        return req & ~done;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port signal bundle for mem_arbiter; bus_err exists only with ARB_TIMEOUT_EN.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              stallreq_if;
    logic              stallreq_mem;
    logic              ram_ce;
    logic              ram_we;
    logic [3:0]        ram_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;
`ifdef ARB_TIMEOUT_EN
    logic              bus_err;
`endif

    // Arbiter side
    modport slave (
`ifdef ARB_TIMEOUT_EN
        output bus_err,
`endif
        input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        input  ram_rdata, ram_ack,
        output if_rdata, if_done, mem_rdata, mem_done, stallreq_if, stallreq_mem,
        output ram_ce, ram_we, ram_sel, ram_addr, ram_wdata
    );

    // Requester / memory-model side
    modport master (
`ifdef ARB_TIMEOUT_EN
        input  bus_err,
`endif
        output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        output ram_rdata, ram_ack,
        input  if_rdata, if_done, mem_rdata, mem_done, stallreq_if, stallreq_mem,
        input  ram_ce, ram_we, ram_sel, ram_addr, ram_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-transaction-at-a-time arbiter of the external memory port, MEM before IF.
// Define ARB_TIMEOUT_EN to add the BUSY watchdog and the bus_err output.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    arb_state_e        state_r, state_s;
    logic              ram_ce_r, ram_ce_s;
    logic              ram_we_r, ram_we_s;
    logic [3:0]        ram_sel_r, ram_sel_s;
    logic [ADDR_W-1:0] ram_addr_r, ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_r, ram_wdata_s;
    logic [DATA_W-1:0] if_rdata_r, if_rdata_s;
    logic [DATA_W-1:0] mem_rdata_r, mem_rdata_s;
    logic              if_done_r, if_done_s;
    logic              mem_done_r, mem_done_s;
    logic [DATA_W-1:0] done_data_s;
    logic              expired_s;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             bus_err_r, bus_err_s;
    // The ack check comes first below, so an ack in the expiry cycle wins.
    assign expired_s   = (cnt_r == CNT_W'(TIMEOUT - 1));
    assign bus.bus_err = bus_err_r;
`else
    assign expired_s   = 1'b0;
`endif

    // Grant selection, field latching and completion decode.
    always_comb begin
        state_s     = state_r;
        ram_ce_s    = ram_ce_r;
        ram_we_s    = ram_we_r;
        ram_sel_s   = ram_sel_r;
        ram_addr_s  = ram_addr_r;
        ram_wdata_s = ram_wdata_r;
        if_rdata_s  = if_rdata_r;
        mem_rdata_s = mem_rdata_r;
        if_done_s   = 1'b0;
        mem_done_s  = 1'b0;
        done_data_s = DATA_W'(ZERO_WORD);
`ifdef ARB_TIMEOUT_EN
        cnt_s       = cnt_r;
        bus_err_s   = 1'b0;
`endif
        case (state_r)
            ARB_IDLE: begin
                if (port_eligible(bus.mem_req, mem_done_r)) begin
                    state_s     = ARB_MEM_BUSY;
                    ram_ce_s    = CHIP_ENABLE;
                    ram_we_s    = bus.mem_we;
                    ram_sel_s   = bus.mem_we ? bus.mem_sel : SEL_ALL;
                    ram_addr_s  = bus.mem_addr;
                    ram_wdata_s = bus.mem_wdata;
`ifdef ARB_TIMEOUT_EN
                    cnt_s       = {CNT_W{1'b0}};
`endif
                end else if (port_eligible(bus.if_req, if_done_r)) begin
                    state_s     = ARB_IF_BUSY;
                    ram_ce_s    = CHIP_ENABLE;
                    ram_we_s    = WRITE_DISABLE;
                    ram_sel_s   = SEL_ALL;
                    ram_addr_s  = bus.if_addr;
                    ram_wdata_s = DATA_W'(ZERO_WORD);
`ifdef ARB_TIMEOUT_EN
                    cnt_s       = {CNT_W{1'b0}};
`endif
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_IF_BUSY, ARB_MEM_BUSY: begin
                if (bus.ram_ack || expired_s) begin
                    state_s  = ARB_IDLE;
                    ram_ce_s = CHIP_DISABLE;
                    if (bus.ram_ack && !ram_we_r) begin
                        done_data_s = bus.ram_rdata;
                    end else begin
                        done_data_s = DATA_W'(ZERO_WORD);
                    end
                    if (state_r == ARB_MEM_BUSY) begin
                        mem_done_s  = 1'b1;
                        mem_rdata_s = done_data_s;
                    end else begin
                        if_done_s  = 1'b1;
                        if_rdata_s = done_data_s;
                    end
`ifdef ARB_TIMEOUT_EN
                    bus_err_s = ~bus.ram_ack;
`endif
                end else begin
                    state_s = state_r;
`ifdef ARB_TIMEOUT_EN
                    cnt_s   = cnt_r + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_s  = ARB_IDLE;
                ram_ce_s = CHIP_DISABLE;
            end
        endcase
    end

    // State and output registers; reset abandons any open transaction.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_r     <= ARB_IDLE;
            ram_ce_r    <= CHIP_DISABLE;
            ram_we_r    <= WRITE_DISABLE;
            ram_sel_r   <= 4'b0000;
            ram_addr_r  <= ADDR_W'(ZERO_WORD);
            ram_wdata_r <= DATA_W'(ZERO_WORD);
            if_rdata_r  <= DATA_W'(ZERO_WORD);
            mem_rdata_r <= DATA_W'(ZERO_WORD);
            if_done_r   <= 1'b0;
            mem_done_r  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_r       <= {CNT_W{1'b0}};
            bus_err_r   <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            ram_ce_r    <= ram_ce_s;
            ram_we_r    <= ram_we_s;
            ram_sel_r   <= ram_sel_s;
            ram_addr_r  <= ram_addr_s;
            ram_wdata_r <= ram_wdata_s;
            if_rdata_r  <= if_rdata_s;
            mem_rdata_r <= mem_rdata_s;
            if_done_r   <= if_done_s;
            mem_done_r  <= mem_done_s;
`ifdef ARB_TIMEOUT_EN
            cnt_r       <= cnt_s;
            bus_err_r   <= bus_err_s;
`endif
        end
    end

    assign bus.ram_ce       = ram_ce_r;
    assign bus.ram_we       = ram_we_r;
    assign bus.ram_sel      = ram_sel_r;
    assign bus.ram_addr     = ram_addr_r;
    assign bus.ram_wdata    = ram_wdata_r;
    assign bus.if_rdata     = if_rdata_r;
    assign bus.mem_rdata    = mem_rdata_r;
    assign bus.if_done      = if_done_r;
    assign bus.mem_done     = mem_done_r;
    assign bus.stallreq_if  = port_eligible(bus.if_req, if_done_r);
    assign bus.stallreq_mem = port_eligible(bus.mem_req, mem_done_r);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model, memory responder, literal checks.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_ON = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ix(input int c);
        return c & 1023;
    endfunction

    // ---------------- memory responder ----------------
    logic [31:0] mem_model [0:255];
    int          ack_delay = 0;
    bit          ack_en = 1'b1;
    bit          force_ack = 1'b0;
    int          busy_n = 0;

    always @(posedge clk) begin
        #2;
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = 32'hFFFF_FFFF;
        if (force_ack) begin
            bus.ram_ack   = 1'b1;
            bus.ram_rdata = 32'h5A5A_5A5A;
        end else if (bus.ram_ce === 1'b1 && ack_en) begin
            if (busy_n == ack_delay) begin
                bus.ram_ack   = 1'b1;
                bus.ram_rdata = mem_model[bus.ram_addr[9:2]];
                if (bus.ram_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.ram_sel[b]) mem_model[bus.ram_addr[9:2]][8*b +: 8] = bus.ram_wdata[8*b +: 8];
                    end
                end
                busy_n = 0;
            end else begin
                busy_n++;
            end
        end else begin
            busy_n = 0;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit          m_valid = 1'b0, m_open = 1'b0, m_port_mem = 1'b0;
    logic        m_ce, m_we, m_if_done = 1'b0, m_mem_done = 1'b0, m_err = 1'b0;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata, data;
    int          m_age;
    bit          cur_if_done, cur_mem_done;

    logic        ce_log [0:1023];
    logic        we_log [0:1023];
    logic        ifd_log [0:1023];
    logic        memd_log [0:1023];
    logic        err_log [0:1023];
    logic [3:0]  sel_log [0:1023];
    logic [31:0] addr_log [0:1023];

    always @(negedge clk) begin
        ce_log[ix(cyc)]   = bus.ram_ce;
        we_log[ix(cyc)]   = bus.ram_we;
        sel_log[ix(cyc)]  = bus.ram_sel;
        addr_log[ix(cyc)] = bus.ram_addr;
        ifd_log[ix(cyc)]  = bus.if_done;
        memd_log[ix(cyc)] = bus.mem_done;
        err_log[ix(cyc)]  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        err_log[ix(cyc)]  = bus.bus_err;
`endif
        if (m_valid) begin
            chk("ram_ce", bus.ram_ce, m_ce);
            chk("ram_we", bus.ram_we, m_we);
            chk("ram_sel", bus.ram_sel, m_sel);
            chk("ram_addr", bus.ram_addr, m_addr);
            chk("ram_wdata", bus.ram_wdata, m_wdata);
            chk("if_done", bus.if_done, m_if_done);
            chk("mem_done", bus.mem_done, m_mem_done);
            chk("if_rdata", bus.if_rdata, m_if_rdata);
            chk("mem_rdata", bus.mem_rdata, m_mem_rdata);
            chk("stallreq_if", bus.stallreq_if, bus.if_req & ~m_if_done);
            chk("stallreq_mem", bus.stallreq_mem, bus.mem_req & ~m_mem_done);
`ifdef ARB_TIMEOUT_EN
            chk("bus_err", bus.bus_err, m_err);
`endif
        end
        // predict the next cycle
        cur_if_done  = m_if_done;
        cur_mem_done = m_mem_done;
        m_if_done  = 1'b0;
        m_mem_done = 1'b0;
        m_err      = 1'b0;
        if (rst) begin
            m_valid = 1'b1; m_open = 1'b0; m_ce = 1'b0; m_we = 1'b0; m_sel = 4'h0;
            m_addr = 32'h0; m_wdata = 32'h0; m_if_rdata = 32'h0; m_mem_rdata = 32'h0;
        end else if (!m_open) begin
            if (bus.mem_req && !cur_mem_done) begin
                m_open = 1'b1; m_port_mem = 1'b1; m_age = 0; m_ce = 1'b1;
                m_we = bus.mem_we; m_sel = bus.mem_we ? bus.mem_sel : 4'hF;
                m_addr = bus.mem_addr; m_wdata = bus.mem_wdata;
            end else if (bus.if_req && !cur_if_done) begin
                m_open = 1'b1; m_port_mem = 1'b0; m_age = 0; m_ce = 1'b1;
                m_we = 1'b0; m_sel = 4'hF; m_addr = bus.if_addr; m_wdata = 32'h0;
            end
        end else begin
            m_age++;
            if (bus.ram_ack || (TO_ON && m_age >= TO)) begin
                data   = (bus.ram_ack && !m_we) ? bus.ram_rdata : 32'h0;
                m_open = 1'b0;
                m_ce   = 1'b0;
                m_err  = !bus.ram_ack;
                if (m_port_mem) begin
                    m_mem_done = 1'b1; m_mem_rdata = data;
                end else begin
                    m_if_done = 1'b1; m_if_rdata = data;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int budget);
        bit drop_if, drop_mem, ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            drop_if  = (bus.if_done === 1'b1);
            drop_mem = (bus.mem_done === 1'b1);
            @(posedge clk);
            #1;
            if (drop_if)  bus.if_req  = 1'b0;
            if (drop_mem) bus.mem_req = 1'b0;
            ok = !bus.if_req && !bus.mem_req;
        end
        chk("run_budget", ok, 1'b1);
    endtask

    function automatic int count_rises(input int a, input int b);
        int n = 0;
        for (int c = a + 1; c <= b; c++) begin
            if (ce_log[ix(c)] && !ce_log[ix(c - 1)]) n++;
        end
        return n;
    endfunction

    // ---------------- directed sequence ----------------
    int c0;

    initial begin
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_sel = 4'h0;
        bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0F00_0000 + i;
        mem_model[8'h40] = 32'h3C01_0001;   // 0x100
        mem_model[8'h41] = 32'h1234_5678;   // 0x104
        mem_model[8'h42] = 32'h0000_1108;   // 0x108
        mem_model[8'h44] = 32'h0000_0110;   // 0x110
        mem_model[8'h80] = 32'hAAAA_5555;   // 0x200

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ram_ce", bus.ram_ce, 1'b0);
        chk("rst_ram_sel", bus.ram_sel, 4'h0);
        chk("rst_ram_addr", bus.ram_addr, 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_mem_done", bus.mem_done, 1'b0);
        tick(1);

        // single fetch, ack two cycles after ram_ce rises; req held through done
        ack_delay = 2; c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
        run_until_idle(60);
        tick(5);
        chk("t1_ce_lat0", ce_log[ix(c0)], 1'b0);
        chk("t1_ce_lat1", ce_log[ix(c0 + 1)], 1'b1);
        chk("t1_addr", addr_log[ix(c0 + 1)], 32'h100);
        chk("t1_no_early_done", ifd_log[ix(c0 + 3)], 1'b0);
        chk("t1_done", ifd_log[ix(c0 + 4)], 1'b1);
        chk("t1_rdata", bus.if_rdata, 32'h3C01_0001);
        chk("t1_one_txn", count_rises(c0, c0 + 9), 1);

        // simultaneous requests with zero-wait memory: MEM write first
        ack_delay = 0; c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0104;
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_sel = 4'b0011;
        bus.mem_addr = 32'h0000_0200; bus.mem_wdata = 32'hDEAD_BEEF;
        run_until_idle(60);
        chk("t2_first_addr", addr_log[ix(c0 + 1)], 32'h200);
        chk("t2_first_we", we_log[ix(c0 + 1)], 1'b1);
        chk("t2_first_sel", sel_log[ix(c0 + 1)], 4'b0011);
        chk("t2_mem_done", memd_log[ix(c0 + 2)], 1'b1);
        chk("t2_idle_gap", ce_log[ix(c0 + 2)], 1'b0);
        chk("t2_second_addr", addr_log[ix(c0 + 3)], 32'h104);
        chk("t2_second_we", we_log[ix(c0 + 3)], 1'b0);
        chk("t2_if_done", ifd_log[ix(c0 + 4)], 1'b1);
        chk("t2_if_rdata", bus.if_rdata, 32'h1234_5678);
        chk("t2_wr_rdata", bus.mem_rdata, 32'h0);

        // no preemption: MEM read arrives during an IF transaction
        tick(2);
        ack_delay = 3; c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0108;
        tick(2);
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_sel = 4'b0101;
        bus.mem_addr = 32'h0000_0200; bus.mem_wdata = 32'h1111_1111;
        run_until_idle(80);
        chk("t3_hold_a", addr_log[ix(c0 + 2)], 32'h108);
        chk("t3_hold_b", addr_log[ix(c0 + 4)], 32'h108);
        chk("t3_if_done", ifd_log[ix(c0 + 5)], 1'b1);
        chk("t3_gap", ce_log[ix(c0 + 5)], 1'b0);
        chk("t3_mem_addr", addr_log[ix(c0 + 6)], 32'h200);
        chk("t3_rd_sel", sel_log[ix(c0 + 6)], 4'hF);
        chk("t3_mem_done", memd_log[ix(c0 + 10)], 1'b1);
        chk("t3_mem_rdata", bus.mem_rdata, 32'hAAAA_BEEF);
        chk("t3_if_hold", bus.if_rdata, 32'h0000_1108);

        // reset at the second BUSY cycle, then a stray ack while idle
        tick(2);
        ack_en = 1'b0; c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_010C;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; bus.if_req = 1'b0;
        tick(1);
        force_ack = 1'b1;
        tick(1);
        force_ack = 1'b0;
        tick(3);
        ack_en = 1'b1;
        chk("t4_busy", ce_log[ix(c0 + 2)], 1'b1);
        chk("t4_ce_after", ce_log[ix(c0 + 3)], 1'b0);
        chk("t4_ifd_after", ifd_log[ix(c0 + 3)], 1'b0);
        chk("t4_memd_after", memd_log[ix(c0 + 3)], 1'b0);
        chk("t4_addr_after", addr_log[ix(c0 + 3)], 32'h0);
        chk("t4_sel_after", sel_log[ix(c0 + 3)], 4'h0);
        chk("t4_stray_ack", ifd_log[ix(c0 + 5)], 1'b0);
        chk("t4_stray_ce", ce_log[ix(c0 + 5)], 1'b0);
        chk("t4_if_rdata", bus.if_rdata, 32'h0);
        chk("t4_mem_rdata", bus.mem_rdata, 32'h0);

`ifdef ARB_TIMEOUT_EN
        // watchdog expiry with no ack
        tick(2);
        ack_en = 1'b0; c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0110;
        run_until_idle(60);
        ack_en = 1'b1;
        chk("t5_busy4", ce_log[ix(c0 + 4)], 1'b1);
        chk("t5_ce_drop", ce_log[ix(c0 + 5)], 1'b0);
        chk("t5_no_early", ifd_log[ix(c0 + 4)], 1'b0);
        chk("t5_done", ifd_log[ix(c0 + 5)], 1'b1);
        chk("t5_err", err_log[ix(c0 + 5)], 1'b1);
        chk("t5_rdata", bus.if_rdata, 32'h0);

        // ack in the expiry cycle wins
        tick(2);
        ack_delay = 3; c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0110;
        run_until_idle(60);
        chk("t6_done", ifd_log[ix(c0 + 5)], 1'b1);
        chk("t6_no_err", err_log[ix(c0 + 5)], 1'b0);
        chk("t6_rdata", bus.if_rdata, 32'h0000_0110);
`endif

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
